// File: rtl/tlul_scratch_dev.sv
// ============================================================================
// Module   : tlul_scratch_dev (with tlul_pkg)
// Brief    : TL-UL device with a word-addressed scratch memory and fixed
//            response latency. Optional macro TLUL_SCRATCH_ERR_EN enables
//            d_error reporting for out-of-range or unsupported requests.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package tlul_pkg;
  localparam logic [2:0] c_op_put_full    = 3'h0;
  localparam logic [2:0] c_op_put_partial = 3'h1;
  localparam logic [2:0] c_op_get         = 3'h4;
  localparam logic [2:0] c_op_ack         = 3'h0;
  localparam logic [2:0] c_op_ack_data    = 3'h1;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;
endpackage

module tlul_scratch_dev #(
  parameter int unsigned Words      = 16,
  parameter int unsigned WaitCycles = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  tlul_pkg::tl_h2d_t  tl_i,
  output tlul_pkg::tl_d2h_t  tl_o
);
  import tlul_pkg::*;

  localparam int unsigned IDX_W  = $clog2(Words);
  localparam logic [3:0]  c_wait = 4'(WaitCycles);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [3:0]         r_cnt;
  logic [31:0]        r_mem [Words];
  logic [2:0]         r_d_opcode;
  logic [7:0]         r_d_source;
  logic [1:0]         r_d_size;
  logic [31:0]        r_d_data;
  logic               r_d_error;

  logic               w_accept;
  logic [IDX_W-1:0]   w_idx;
  logic               w_is_put;
  logic               w_is_get;
  logic               w_err;
  logic               w_ack_data;
  logic               w_write;
  logic               w_unused;

  // Fields outside the decoded set (param, user, low/high address bits) are
  // intentionally ignored.
  assign w_unused = ^tl_i;

  assign w_accept = (r_state == ST_IDLE) && tl_i.a_valid;
  assign w_idx    = tl_i.a_address[2 +: IDX_W];
  assign w_is_put = (tl_i.a_opcode == c_op_put_full) ||
                    (tl_i.a_opcode == c_op_put_partial);
  assign w_is_get = (tl_i.a_opcode == c_op_get);

`ifdef TLUL_SCRATCH_ERR_EN
  assign w_err      = ({2'b00, tl_i.a_address[31:2]} >= 32'(Words)) ||
                      !(w_is_put || w_is_get);
  assign w_ack_data = w_is_get;
`else
  // Anything that is not a Put is served as a Get; addresses alias.
  assign w_err      = 1'b0;
  assign w_ack_data = !w_is_put;
`endif

  assign w_write = w_accept && w_is_put && !w_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (tl_i.a_valid) begin
          w_state_next = (c_wait != 4'd0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        if (tl_i.d_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt      <= 4'd0;
      r_d_opcode <= 3'd0;
      r_d_source <= 8'd0;
      r_d_size   <= 2'd0;
      r_d_data   <= 32'd0;
      r_d_error  <= 1'b0;
      for (int i = 0; i < int'(Words); i++) begin
        r_mem[i] <= 32'd0;
      end
    end else begin
      if (w_accept) begin
        r_cnt      <= c_wait;
        r_d_opcode <= w_ack_data ? c_op_ack_data : c_op_ack;
        r_d_source <= tl_i.a_source;
        r_d_size   <= tl_i.a_size;
        r_d_error  <= w_err;
        r_d_data   <= (w_ack_data && !w_err) ? r_mem[w_idx] : 32'd0;
      end else if (r_state == ST_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_write) begin
        for (int k = 0; k < 4; k++) begin
          if (tl_i.a_mask[k]) begin
            r_mem[w_idx][8*k +: 8] <= tl_i.a_data[8*k +: 8];
          end
        end
      end
    end
  end

  // Handshake signals come from state alone so reset kills d_valid at once.
  always_comb begin
    tl_o          = '0;
    tl_o.a_ready  = (r_state == ST_IDLE);
    tl_o.d_valid  = (r_state == ST_RESP);
    tl_o.d_opcode = r_d_opcode;
    tl_o.d_source = r_d_source;
    tl_o.d_size   = r_d_size;
    tl_o.d_data   = r_d_data;
    tl_o.d_error  = r_d_error;
  end

endmodule

`default_nettype wire

// File: tb/tb_tlul_scratch_dev.sv
// ============================================================================
// Module   : tb_tlul_scratch_dev
// Brief    : Scoreboard bench for tlul_scratch_dev, zero- and three-wait builds.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_tlul_scratch_dev;
  import tlul_pkg::*;

  localparam int c_w1 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  tl_h2d_t     h2d [2];
  tl_d2h_t     d2h [2];
  logic [31:0] mdl [2][16];
  tl_d2h_t     sb  [2][$];
  int          c_wait [2] = '{0, c_w1};
  int          n_total = 0;
  int          n_bad   = 0;

  always #5 clk = ~clk;

  tlul_scratch_dev #(.Words(16), .WaitCycles(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .tl_i(h2d[0]), .tl_o(d2h[0])
  );
  tlul_scratch_dev #(.Words(16), .WaitCycles(c_w1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .tl_i(h2d[1]), .tl_o(d2h[1])
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_models();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) mdl[p][i] = 32'd0;
      sb[p].delete();
    end
  endtask

  function automatic tl_d2h_t model(input int p, input logic [2:0] op, input logic [31:0] addr,
                                    input logic [31:0] data, input logic [3:0] mask,
                                    input logic [7:0] src);
    tl_d2h_t r;
    logic    err;
    logic    put;
    logic    get;
    logic    ackd;
    int      idx;
    r   = '0;
    err = 1'b0;
    idx = int'(addr[5:2]);
    put = (op == c_op_put_full) || (op == c_op_put_partial);
    get = (op == c_op_get);
`ifdef TLUL_SCRATCH_ERR_EN
    err  = (addr[31:2] >= 30'd16) || !(put || get);
    ackd = get;
`else
    ackd = !put;
`endif
    if (put && !err) begin
      for (int k = 0; k < 4; k++) begin
        if (mask[k]) mdl[p][idx][8*k +: 8] = data[8*k +: 8];
      end
    end
    r.d_valid  = 1'b1;
    r.d_opcode = ackd ? c_op_ack_data : c_op_ack;
    r.d_size   = 2'd2;
    r.d_source = src;
    r.d_error  = err;
    r.d_data   = (ackd && !err) ? mdl[p][idx] : 32'd0;
    return r;
  endfunction

  task automatic issue(input int p, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] mask, input logic [7:0] src);
    @(negedge clk);
    chk("a_ready_idle", 128'(d2h[p].a_ready), 128'(1'b1));
    h2d[p].a_valid   = 1'b1;
    h2d[p].a_opcode  = op;
    h2d[p].a_address = addr;
    h2d[p].a_data    = data;
    h2d[p].a_mask    = mask;
    h2d[p].a_source  = src;
    h2d[p].a_size    = 2'd2;
    sb[p].push_back(model(p, op, addr, data, mask, src));
    @(posedge clk);
    #1;
    h2d[p].a_valid = 1'b0;
  endtask

  task automatic wait_resp(input int p);
    int lat;
    lat = 0;
    while (!d2h[p].d_valid && lat < 40) begin
      chk("a_ready_busy", 128'(d2h[p].a_ready), 128'(1'b0));
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 128'(lat), 128'(c_wait[p]));
  endtask

  task automatic complete(input int p, input int stall);
    tl_d2h_t snap;
    tl_d2h_t exp;
    wait_resp(p);
    snap = d2h[p];
    repeat (stall) begin
      @(posedge clk);
      #1;
      chk("stall_hold", 128'(d2h[p]), 128'(snap));
    end
    if (sb[p].size() == 0) begin
      chk("sb_empty", 128'(1), 128'(0));
      exp = '0;
    end else begin
      exp = sb[p].pop_front();
    end
    chk("d_data", 128'(d2h[p].d_data), 128'(exp.d_data));
    chk("resp", 128'(d2h[p]), 128'(exp));
    h2d[p].d_ready = 1'b1;
    @(posedge clk);
    #1;
    h2d[p].d_ready = 1'b0;
    chk("d_valid_drop", 128'(d2h[p].d_valid), 128'(1'b0));
    chk("a_ready_back", 128'(d2h[p].a_ready), 128'(1'b1));
  endtask

  task automatic xact(input int p, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] mask, input logic [7:0] src,
                      input int stall);
    issue(p, op, addr, data, mask, src);
    complete(p, stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tl_d2h_t idle_exp;
    idle_exp         = '0;
    idle_exp.a_ready = 1'b1;
    h2d[0] = '0;
    h2d[1] = '0;
    clear_models();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state0", 128'(d2h[0]), 128'(idle_exp));
    chk("reset_state1", 128'(d2h[1]), 128'(idle_exp));

    xact(0, c_op_get,         32'h0, 32'h0,        4'hF, 8'h11, 0);
    xact(0, c_op_put_full,    32'h4, 32'h12345678, 4'hF, 8'h22, 0);
    xact(0, c_op_get,         32'h4, 32'h0,        4'h0, 8'h23, 0);
    xact(0, c_op_put_partial, 32'h4, 32'hFFFFFF01, 4'h1, 8'h24, 1);
    xact(0, c_op_get,         32'h4, 32'h0,        4'hF, 8'h25, 0);
    xact(0, c_op_put_partial, 32'h4, 32'hFFFFFF01, 4'hC, 8'h26, 0);
    xact(0, c_op_get,         32'h7, 32'h0,        4'hF, 8'h27, 0);

    xact(1, c_op_put_full,    32'h10, 32'hCAFEF00D, 4'hF, 8'h31, 5);
    xact(1, c_op_get,         32'h10, 32'h0,        4'hF, 8'h32, 5);

    xact(0, 3'd2,             32'h4,  32'h0,        4'hF, 8'h41, 0);
    xact(0, c_op_get,         32'h40, 32'h0,        4'hF, 8'h42, 0);
    xact(0, c_op_put_full,    32'h44, 32'hDEADBEEF, 4'hF, 8'h43, 0);
    xact(0, c_op_get,         32'h4,  32'h0,        4'hF, 8'h44, 0);

    for (int i = 0; i < 12; i++) begin
      logic [2:0] op;
      int         sel;
      sel = int'($urandom_range(0, 2));
      op  = (sel == 0) ? c_op_put_full : (sel == 1) ? c_op_put_partial : c_op_get;
      xact(0, op, {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom,
           4'($urandom_range(1, 15)), 8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
    end

    issue(0, c_op_put_full, 32'h8, 32'hA5A5A5A5, 4'hF, 8'h51);
    wait_resp(0);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_d_valid", 128'(d2h[0].d_valid), 128'(1'b0));
    chk("rst_a_ready", 128'(d2h[0].a_ready), 128'(1'b1));
    clear_models();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_late_ack", 128'(d2h[0].d_valid), 128'(1'b0));
    end
    xact(0, c_op_get, 32'h8, 32'h0, 4'hF, 8'h52, 0);
    xact(1, c_op_get, 32'h10, 32'h0, 4'hF, 8'h53, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
